// File: rtl/alien_formation_if.sv
// Handshake bundle between the alien formation stepper and the
// bullet/collision stage.
interface alien_formation_if;
    logic [49:0] Aliens_Grid;
    logic        Collision;
    logic        Aliens_Defeated;
    logic [8:0]  Player_Row;
    logic [8:0]  Aliens_Row;
    logic [9:0]  Aliens_Col;
    logic        Direction;
    logic        Step_Pulse;
    logic        Aliens_Landed;
    logic [3:0]  Wave_Count;

    modport master (
        output Aliens_Grid, Collision, Aliens_Defeated, Player_Row,
        input  Aliens_Row, Aliens_Col, Direction, Step_Pulse,
        input  Aliens_Landed, Wave_Count
    );

    modport slave (
        input  Aliens_Grid, Collision, Aliens_Defeated, Player_Row,
        output Aliens_Row, Aliens_Col, Direction, Step_Pulse,
        output Aliens_Landed, Wave_Count
    );
endinterface

// File: rtl/alien_formation.sv
// Alien formation stepper: marches the 10x5 grid, descends at the
// screen edges, speeds up on kills and flags a landing.
module alien_formation #(
    parameter int StartCol    = 120,
    parameter int StartRow    = 40,
    parameter int StepX       = 8,
    parameter int StepY       = 10,
    parameter int LeftBound   = 8,
    parameter int RightBound  = 632,
    parameter int StartPeriod = 30,
    parameter int MinPeriod   = 4,
    parameter int AlienWidth  = 30,
    parameter int AlienHeight = 20
) (
    input  logic Clk,
    input  logic Reset,
    alien_formation_if.slave bus
);

    localparam logic [10:0] ColPitch = 11'd40;
    localparam logic [10:0] RowPitch = 11'd30;

    typedef enum logic [1:0] {
        MARCH_R,
        MARCH_L,
        LANDED
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic        dir_q, dir_d;
    logic [4:0]  period_q, period_d;
    logic [4:0]  timer_q, timer_d;
    logic        step_q, step_d;
    logic [3:0]  wave_q, wave_d;

    logic [9:0]  col_alive;
    logic [4:0]  row_alive;
    logic [3:0]  lc, rc;
    logic [2:0]  br;
    logic        right_ok, left_ok, land_hit, timer_hit;

    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                col_alive[c] = col_alive[c] | bus.Aliens_Grid[r*10+c];
                row_alive[r] = row_alive[r] | bus.Aliens_Grid[r*10+c];
            end
        end
        lc = '0;
        for (int c = 9; c >= 0; c--) begin
            if (col_alive[c]) lc = 4'(c);
        end
        rc = '0;
        for (int c = 0; c < 10; c++) begin
            if (col_alive[c]) rc = 4'(c);
        end
        br = '0;
        for (int r = 0; r < 5; r++) begin
            if (row_alive[r]) br = 3'(r);
        end
    end

    // 11-bit edge math so the pixel sums never wrap
    assign right_ok = (11'(col_q) + 11'(StepX) + 11'(rc) * ColPitch
                       + 11'(AlienWidth)) <= 11'(RightBound);
    assign left_ok  = 11'(col_q) >= (11'(LeftBound) + 11'(StepX)
                       + 11'(lc) * ColPitch);
    assign land_hit = (|bus.Aliens_Grid) &&
                      ((11'(row_q) + 11'(br) * RowPitch + 11'(AlienHeight))
                       >= 11'(bus.Player_Row));
    // >= so a shortened period fires at once on an overrun timer
    assign timer_hit = timer_q >= (period_q - 5'd1);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        dir_d    = dir_q;
        period_d = period_q;
        timer_d  = timer_q;
        step_d   = 1'b0;
        wave_d   = wave_q;

        if (bus.Aliens_Defeated && state_q != LANDED) begin
            state_d  = MARCH_R;
            col_d    = 10'(StartCol);
            row_d    = 9'(StartRow);
            dir_d    = 1'b1;
            period_d = 5'(StartPeriod);
            timer_d  = '0;
            if (wave_q != 4'd15) wave_d = wave_q + 4'd1;
        end else if (state_q == LANDED) begin
            state_d = LANDED;
        end else if (land_hit) begin
            state_d = LANDED;
        end else begin
            if (bus.Collision) begin
                period_d = (period_q > 5'(MinPeriod)) ?
                           period_q - 5'd1 : 5'(MinPeriod);
            end
            if (timer_hit) begin
                timer_d = '0;
                step_d  = 1'b1;
                unique case (state_q)
                    MARCH_R: begin
                        if (right_ok) begin
                            col_d = col_q + 10'(StepX);
                        end else begin
                            row_d   = row_q + 9'(StepY);
                            dir_d   = 1'b0;
                            state_d = MARCH_L;
                        end
                    end
                    MARCH_L: begin
                        if (left_ok) begin
                            col_d = col_q - 10'(StepX);
                        end else begin
                            row_d   = row_q + 9'(StepY);
                            dir_d   = 1'b1;
                            state_d = MARCH_R;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end else begin
                timer_d = timer_q + 5'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= MARCH_R;
            col_q    <= 10'(StartCol);
            row_q    <= 9'(StartRow);
            dir_q    <= 1'b1;
            period_q <= 5'(StartPeriod);
            timer_q  <= '0;
            step_q   <= 1'b0;
            wave_q   <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
            wave_q   <= wave_d;
        end
    end

    assign bus.Aliens_Col    = col_q;
    assign bus.Aliens_Row    = row_q;
    assign bus.Direction     = dir_q;
    assign bus.Step_Pulse    = step_q;
    assign bus.Aliens_Landed = (state_q == LANDED);
    assign bus.Wave_Count    = wave_q;

endmodule

// File: doc/alien_formation.md
Name: alien_formation

Overview:
- Generates the alien-formation anchor position (Aliens_Row, Aliens_Col) consumed by the bullet/collision stage.
- Consumes that stage's Aliens_Grid, Collision and Aliens_Defeated.
- Marches the 10x5 formation left/right, descends and reverses at the screen edges, and speeds up as aliens are destroyed.
- Flags a landing when the lowest surviving row reaches the player row. Clk is the game tick.

Parameters:
- StartCol, 120, anchor column at reset and at new wave (pixels)
- StartRow, 40, anchor row at reset and at new wave (pixels)
- StepX, 8, horizontal pixels per march step
- StepY, 10, vertical pixels per descend step
- LeftBound, 8, minimum allowed left pixel of the leftmost occupied column
- RightBound, 632, maximum allowed right pixel of the rightmost occupied column
- StartPeriod, 30, ticks between steps at wave start
- MinPeriod, 4, period floor
- AlienWidth/AlienHeight, 30/20, alien size; column pitch 40, row pitch 30 (fixed)

Ports:
- Clk  in  1  game clock
- Reset  in  1  synchronous, active-high
- Aliens_Grid  in  50  alive mask, bit index = row*10+col
- Collision  in  1  one-tick pulse, an alien was destroyed
- Aliens_Defeated  in  1  grid empty, new wave
- Player_Row  in  9  player top row (pixels)
- Aliens_Row  out  9  formation anchor row
- Aliens_Col  out  10  formation anchor column
- Direction  out  1  1 = moving right, 0 = moving left
- Step_Pulse  out  1  one-tick pulse on every step (march or descend)
- Aliens_Landed  out  1  sticky; formation reached the player row
- Wave_Count  out  4  waves started since reset, saturates at 15

Behaviour:
- Reset, clock: Reset and Clk are synchronous, active-high reset.
- Reset values:
  - Aliens_Col=StartCol, Aliens_Row=StartRow
  - Direction=1, state MARCH_R
  - period=StartPeriod, timer=0
  - Step_Pulse=0, Aliens_Landed=0, Wave_Count=0
- Edge logic (combinational from Aliens_Grid):
  - colAlive[c] = OR of the 5 bits of column c; Lc/Rc = lowest/highest alive column.
  - rowAlive[r] = OR of the 10 bits of row r; Br = highest alive row.
  - All edge math is 11-bit unsigned, no wrap.
- Right test: Aliens_Col + StepX + Rc*40 + 30 <= RightBound.
- Left test: Aliens_Col >= LeftBound + StepX + Lc*40.
- Timer:
  - Increments each tick.
  - When timer == period-1: timer <= 0 and a step occurs, with Step_Pulse=1 for that one tick.
- States:
  - MARCH_R: on a step, Col += StepX if the right test passes. Otherwise Row += StepY, Direction <= 0, go to MARCH_L. The descend replaces the horizontal move.
  - MARCH_L: mirror of MARCH_R, using the left test and Col -= StepX. On descend, Direction <= 1.
  - LANDED: no steps, timer held, Step_Pulse=0, Aliens_Landed=1. Exit only via Reset.
- Landing:
  - After any register update, if Aliens_Row + Br*30 + 20 >= Player_Row, go to LANDED on the next tick.
  - Landing is evaluated only when the grid is non-empty.
- Speedup:
  - Each Collision pulse: period <= max(period-1, MinPeriod).
  - A new period applies from the next compare.
  - If the timer already exceeds the new period-1, the step fires on the next tick.
  - Collision and a step in the same tick: both take effect.
- New wave:
  - Aliens_Defeated=1 (not in LANDED): Col/Row <= Start values, Direction=1, MARCH_R, period=StartPeriod, timer=0.
  - Wave_Count += 1 (saturating). Asserted for consecutive ticks, it increments once per tick.
  - No step occurs that tick.
  - Takes priority over step and Collision.
- Priority: Reset > Aliens_Defeated > LANDED hold > step/Collision.
- Reset mid-step or mid-descend restores all reset values in one tick.

Test Plan:
- Reset held 3 ticks, full grid, Player_Row=440 -> Col=120, Row=40, Direction=1, Landed=0, Wave_Count=0. First Step_Pulse 30 ticks after release, Col=128.
- Full grid, free run -> Col reaches 240 after 15 steps. Step 16: Row=50, Col=240, Direction=0. Step 17: Col=232.
- Clear column 9 (bits 9,19,29,39,49) before the first step -> march continues to Col=280 before the first descend.
- 26 Collision pulses -> period saturates at 4 and steps are 4 ticks apart. A 27th pulse leaves the period at 4. Collision coincident with a step -> step still taken.
- Only row 0 alive, Player_Row=100 -> landing when Row+20>=100 (Row=80 after descends). Landed=1, Col/Row frozen, no Step_Pulse. Aliens_Defeated ignored until Reset.
- Aliens_Defeated pulse mid-march at Col=200, Row=70 -> next tick Col=120, Row=40, Direction=1, Wave_Count=1, timer restarted. Reset at timer=29 -> no step.
